// File: rtl/ft_pkg.sv
// Shared definitions for the triple-core fault-tolerant system.
package ft_pkg;

    // Number of redundant cores; the voter uses the same constant.
    localparam int NUM_CORES = 3;

    // Index of one core (source-core select, etc.).
    typedef logic [$clog2(NUM_CORES)-1:0] core_idx_t;

    // Recovery sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        HALT,
        COPY,
        PC,
        RESUME,
        FAIL
    } state_t;

endpackage

// File: rtl/copy_engine.sv
// Register-file copy engine: walks addresses 0..NUM_REG, reading the source
// core and writing the returned data one cycle later into the faulty core.
module copy_engine #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CORES  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_start,
    input  logic [NUM_CORES-1:0]  i_mask,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic [NUM_CORES-1:0]  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_done
);

    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam int IDX_W   = ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REG);

    logic             r_active;
    logic [IDX_W-1:0] r_idx;
    logic             w_rd_phase;
    logic             w_wr_phase;

    // Address counter: runs 0..NUM_REG once per start, then parks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active <= 1'b0;
            r_idx    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            if (r_idx == IDX_LAST) begin
                r_active <= 1'b0;
                r_idx    <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Reads cover indices 0..NUM_REG-1; writes trail by one cycle and
    // cover indices 1..NUM_REG, so data returned for address i-1 lands now.
    assign w_rd_phase = r_active && (r_idx != IDX_LAST);
    assign w_wr_phase = r_active && (r_idx != '0);

    assign o_raddr = w_rd_phase ? r_idx[ADDR_WIDTH-1:0] : '0;
    assign o_we    = w_wr_phase ? i_mask : '0;
    assign o_waddr = w_wr_phase ? ADDR_WIDTH'(r_idx - IDX_W'(1)) : '0;
    assign o_wdata = w_wr_phase ? i_rdata : '0;
    assign o_done  = r_active && (r_idx == IDX_LAST);

endmodule

// File: rtl/recovery_sequencer.sv
// Recovery sequencer: on a voter mismatch, halts all cores, copies the
// register file from a healthy core into the faulty one, triggers the PC
// copy and resumes. Unrecoverable conditions latch a sticky failure flag.
module recovery_sequencer #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CORES    = ft_pkg::NUM_CORES,
    parameter int HALT_TIMEOUT = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         error_i,
    input  logic [NUM_CORES-1:0]         faulty_i,
    input  logic [NUM_CORES-1:0]         halted_i,
    output logic [NUM_CORES-1:0]         halt_o,
    output logic [$clog2(NUM_CORES)-1:0] rf_rsel_o,
    output logic [ADDR_WIDTH-1:0]        rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]        rf_rdata_i,
    output logic [NUM_CORES-1:0]         rf_we_o,
    output logic [ADDR_WIDTH-1:0]        rf_waddr_o,
    output logic [DATA_WIDTH-1:0]        rf_wdata_o,
    output logic                         pc_copy_o,
    output logic                         resume_o,
    output logic                         busy_o,
    output logic                         fail_o,
    output logic [7:0]                   recoveries_o
);

    localparam int SEL_W  = $clog2(NUM_CORES);
    localparam int WAIT_W = $clog2(HALT_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(HALT_TIMEOUT - 1);

    // True when exactly one core is flagged.
    function automatic logic f_onehot(input logic [NUM_CORES-1:0] v);
        return (v != '0) && ((v & (v - NUM_CORES'(1))) == '0);
    endfunction

    // Lowest-index core that is not flagged as faulty.
    function automatic logic [SEL_W-1:0] f_source(input logic [NUM_CORES-1:0] v);
        logic [SEL_W-1:0] src;
        src = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (!v[c]) src = SEL_W'(c);
        end
        return src;
    endfunction

    ft_pkg::state_t        r_state;
    logic [NUM_CORES-1:0]  r_fault;
    logic [SEL_W-1:0]      r_rsel;
    logic [WAIT_W-1:0]     r_wait;
    logic [NUM_CORES-1:0]  r_halt;
    logic                  r_pc_copy;
    logic                  r_resume;
    logic                  r_busy;
    logic                  r_fail;
    logic [7:0]            r_recoveries;

    logic                  w_all_halted;
    logic                  w_copy_start;
    logic                  w_copy_done;

    assign w_all_halted = &halted_i;
    assign w_copy_start = (r_state == ft_pkg::HALT) && w_all_halted;

    // Recovery FSM with registered outputs, halt timeout and recovery count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ft_pkg::IDLE;
            r_fault      <= '0;
            r_rsel       <= '0;
            r_wait       <= '0;
            r_halt       <= '0;
            r_pc_copy    <= 1'b0;
            r_resume     <= 1'b0;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
            r_recoveries <= '0;
        end else begin
            case (r_state)
                ft_pkg::IDLE: begin
                    if (error_i) begin
                        r_halt <= '1;
                        if (f_onehot(faulty_i)) begin
                            r_state <= ft_pkg::HALT;
                            r_fault <= faulty_i;
                            r_rsel  <= f_source(faulty_i);
                            r_wait  <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ft_pkg::FAIL;
                            r_fail  <= 1'b1;
                        end
                    end
                end
                ft_pkg::HALT: begin
                    if (w_all_halted) begin
                        r_state <= ft_pkg::COPY;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= ft_pkg::FAIL;
                        r_busy  <= 1'b0;
                        r_fail  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ft_pkg::COPY: begin
                    if (w_copy_done) begin
                        r_state   <= ft_pkg::PC;
                        r_pc_copy <= 1'b1;
                    end
                end
                ft_pkg::PC: begin
                    r_state   <= ft_pkg::RESUME;
                    r_pc_copy <= 1'b0;
                    r_resume  <= 1'b1;
                    r_halt    <= '0;
                end
                ft_pkg::RESUME: begin
                    r_state  <= ft_pkg::IDLE;
                    r_resume <= 1'b0;
                    r_busy   <= 1'b0;
                    if (r_recoveries != 8'hFF) begin
                        r_recoveries <= r_recoveries + 8'd1;
                    end
                end
                default: begin
                    // FAIL: parked with cores halted until reset.
                    r_state   <= ft_pkg::FAIL;
                    r_halt    <= '1;
                    r_pc_copy <= 1'b0;
                    r_resume  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_fail    <= 1'b1;
                end
            endcase
        end
    end

    copy_engine #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CORES  (NUM_CORES)
    ) u_copy_engine (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_start (w_copy_start),
        .i_mask  (r_fault),
        .i_rdata (rf_rdata_i),
        .o_raddr (rf_raddr_o),
        .o_we    (rf_we_o),
        .o_waddr (rf_waddr_o),
        .o_wdata (rf_wdata_o),
        .o_done  (w_copy_done)
    );

    assign halt_o       = r_halt;
    assign rf_rsel_o    = r_rsel;
    assign pc_copy_o    = r_pc_copy;
    assign resume_o     = r_resume;
    assign busy_o       = r_busy;
    assign fail_o       = r_fail;
    assign recoveries_o = r_recoveries;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Bench for recovery_sequencer: table of recovery scenarios plus hand-written
// timeout, multi-hot, mid-copy reset and counter saturation sequences.
module tb_recovery_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        error_i;
    logic [2:0]  faulty_i;
    logic [2:0]  halted_i;
    logic [2:0]  halt_o;
    logic [1:0]  rf_rsel_o;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i = '0;
    logic [2:0]  rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        pc_copy_o;
    logic        resume_o;
    logic        busy_o;
    logic        fail_o;
    logic [7:0]  recoveries_o;

    int n_cmp = 0;
    int n_bad = 0;

    recovery_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .error_i      (error_i),
        .faulty_i     (faulty_i),
        .halted_i     (halted_i),
        .halt_o       (halt_o),
        .rf_rsel_o    (rf_rsel_o),
        .rf_raddr_o   (rf_raddr_o),
        .rf_rdata_i   (rf_rdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .pc_copy_o    (pc_copy_o),
        .resume_o     (resume_o),
        .busy_o       (busy_o),
        .fail_o       (fail_o),
        .recoveries_o (recoveries_o)
    );

    always #5 clk_i = ~clk_i;

    // Source register-file contents: RF[k] = k*3, tagged with the core index
    // in the top nibble so a wrong source selection shows up in the data.
    function automatic logic [31:0] rf_val(input logic [1:0] core, input logic [4:0] a);
        return (32'(a) * 32'd3) + (32'(core) << 28);
    endfunction

    // Register file read port model: one-cycle read latency.
    always @(posedge clk_i) rf_rdata_i <= rf_val(rf_rsel_o, rf_raddr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {2'b0, halt_o, rf_rsel_o, rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
                pc_copy_o, resume_o, busy_o, fail_o, recoveries_o};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni   = 1'b0;
        error_i  = 1'b0;
        faulty_i = '0;
        halted_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic [2:0] faulty;
        int         delay;
        logic [1:0] src;
        int         resume_cyc;
        logic [7:0] count;
    } vec_t;

    // One full recovery; cycle 1 is the cycle after the edge sampling error_i.
    task automatic run_recovery(input vec_t v);
        int c, nwr, pc_cyc, res_cyc, busy_low, wrong_we;
        bit got;
        c = 0; nwr = 0; pc_cyc = -1; res_cyc = -1; busy_low = 0; wrong_we = 0; got = 0;
        @(negedge clk_i);
        error_i  = 1'b1;
        faulty_i = v.faulty;
        halted_i = (v.delay == 0) ? 3'b111 : 3'b000;
        @(posedge clk_i);
        #1 error_i = 1'b0;
        while (!got && c < 120) begin
            @(negedge clk_i);
            c++;
            if (c == 1 + v.delay) halted_i = 3'b111;
            if (c == 1) begin
                chk("rsel", 64'(rf_rsel_o), 64'(v.src));
                chk("halt_c1", 64'(halt_o), 64'h7);
            end
            if (!busy_o) busy_low++;
            if ((rf_we_o & ~v.faulty) != 3'b000) wrong_we++;
            if (rf_we_o != 3'b000) begin
                chk("waddr", 64'(rf_waddr_o), 64'(nwr));
                chk("wdata", 64'(rf_wdata_o), 64'(rf_val(v.src, 5'(nwr))));
                nwr++;
            end
            if (pc_copy_o) pc_cyc = c;
            if (resume_o) begin
                res_cyc = c;
                got = 1;
                chk("halt_at_resume", 64'(halt_o), 64'h0);
            end
        end
        chk("resume_seen", 64'(got), 64'h1);
        chk("resume_cycle", 64'(res_cyc), 64'(v.resume_cyc));
        chk("pc_cycle", 64'(pc_cyc), 64'(v.resume_cyc - 1));
        chk("write_count", 64'(nwr), 64'd32);
        chk("busy_low_cycles", 64'(busy_low), 64'h0);
        chk("we_non_faulty", 64'(wrong_we), 64'h0);
        @(negedge clk_i);
        chk("recoveries", 64'(recoveries_o), 64'(v.count));
        chk("busy_after", 64'(busy_o), 64'h0);
    endtask

    vec_t vecs[4];

    initial begin
        int c, we_seen;
        bit reached;

        vecs[0] = '{faulty: 3'b010, delay: 0, src: 2'd0, resume_cyc: 36, count: 8'd1};
        vecs[1] = '{faulty: 3'b001, delay: 0, src: 2'd1, resume_cyc: 36, count: 8'd2};
        vecs[2] = '{faulty: 3'b010, delay: 5, src: 2'd0, resume_cyc: 41, count: 8'd3};
        vecs[3] = '{faulty: 3'b100, delay: 2, src: 2'd0, resume_cyc: 38, count: 8'd4};

        rst_ni = 1'b0; error_i = 1'b0; faulty_i = '0; halted_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", all_outs(), 64'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_outputs", all_outs(), 64'h0);

        for (int i = 0; i < 4; i++) run_recovery(vecs[i]);

        // Halt timeout: core 2 never acknowledges.
        do_reset();
        @(negedge clk_i);
        error_i = 1'b1; faulty_i = 3'b100; halted_i = 3'b011;
        @(posedge clk_i);
        we_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (rf_we_o != 3'b000) we_seen++;
            if (k == 16) begin
                chk("to_c16_fail", 64'(fail_o), 64'h0);
                chk("to_c16_busy", 64'(busy_o), 64'h1);
            end
            if (k == 17) begin
                chk("to_c17_fail", 64'(fail_o), 64'h1);
                chk("to_c17_halt", 64'(halt_o), 64'h7);
                chk("to_c17_busy", 64'(busy_o), 64'h0);
            end
        end
        chk("to_sticky", 64'(fail_o), 64'h1);
        chk("to_no_we", 64'(we_seen), 64'h0);
        chk("to_no_resume", 64'(resume_o), 64'h0);
        error_i = 1'b0;

        // Multi-hot faulty vector.
        do_reset();
        @(negedge clk_i);
        error_i = 1'b1; faulty_i = 3'b011; halted_i = 3'b111;
        @(posedge clk_i);
        #1 error_i = 1'b0;
        @(negedge clk_i);
        chk("mh_fail", 64'(fail_o), 64'h1);
        chk("mh_halt", 64'(halt_o), 64'h7);
        chk("mh_busy", 64'(busy_o), 64'h0);
        we_seen = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (rf_we_o != 3'b000) we_seen++;
        end
        chk("mh_no_we", 64'(we_seen), 64'h0);

        // Reset during copy, then a clean recovery afterwards.
        do_reset();
        run_recovery('{faulty: 3'b100, delay: 0, src: 2'd0, resume_cyc: 36, count: 8'd1});
        @(negedge clk_i);
        error_i = 1'b1; faulty_i = 3'b001; halted_i = 3'b111;
        @(posedge clk_i);
        #1 error_i = 1'b0;
        c = 0;
        reached = 0;
        while (!reached && c < 60) begin
            @(negedge clk_i);
            c++;
            if (busy_o && rf_raddr_o == 5'd10 && c >= 2) reached = 1;
        end
        chk("mr_addr10_cycle", 64'(c), 64'd12);
        rst_ni = 1'b0;
        #1;
        chk("mr_outputs_zero", all_outs(), 64'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        run_recovery('{faulty: 3'b001, delay: 0, src: 2'd1, resume_cyc: 36, count: 8'd1});

        // Back-to-back recoveries with error held high, up to saturation.
        @(negedge clk_i);
        error_i = 1'b1; faulty_i = 3'b010; halted_i = 3'b111;
        reached = 0;
        for (int k = 0; k < 12000 && !reached; k++) begin
            @(negedge clk_i);
            if (recoveries_o == 8'hFF) reached = 1;
        end
        chk("sat_reached", 64'(reached), 64'h1);
        repeat (80) @(negedge clk_i);
        error_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("sat_hold", 64'(recoveries_o), 64'hFF);
        chk("sat_no_fail", 64'(fail_o), 64'h0);
        chk("sat_idle", 64'(busy_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/recovery_sequencer.md
# recovery_sequencer

Recovery sequencer for the triple-core fault-tolerant system. When the voter flags a mismatch, it halts all cores and copies the full register file from a healthy core into the faulty one. It then triggers the PC copy and resumes the cores. It drives the shared register-file copy port and the per-core halt/resume lines. Unrecoverable conditions are reported through a sticky failure flag.

## Interface
- ADDR_WIDTH, 5, register-file address width; NUM_REG = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NUM_CORES, 3, number of redundant cores
- HALT_TIMEOUT, 16, max cycles to wait for all halt acknowledges
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- error_i  in  1  voter mismatch; level, sampled only in IDLE
- faulty_i  in  NUM_CORES  one-hot faulty-core vector; valid while error_i=1
- halted_i  in  NUM_CORES  per-core halt acknowledge
- halt_o  out  NUM_CORES  halt request per core
- rf_rsel_o  out  $clog2(NUM_CORES)  source core for register read
- rf_raddr_o  out  ADDR_WIDTH  read address to the source core
- rf_rdata_i  in  DATA_WIDTH  read data; valid exactly 1 cycle after rf_raddr_o
- rf_we_o  out  NUM_CORES  write enable; only the faulty core's bit may be set
- rf_waddr_o  out  ADDR_WIDTH  write address
- rf_wdata_o  out  DATA_WIDTH  write data (rf_rdata_i passed through)
- pc_copy_o  out  1  one-cycle pulse: faulty core loads PC from source
- resume_o  out  1  one-cycle pulse releasing all cores
- busy_o  out  1  high in every state except IDLE and FAIL
- fail_o  out  1  sticky unrecoverable-fault flag
- recoveries_o  out  8  count of completed recoveries, saturates at 255

## Operation
- Reset values: all outputs are 0; the state is IDLE; the count is 0.
- All outputs are registered, or decoded from registered state only.
- IDLE
  - error_i=1 with one-hot faulty_i: latch faulty_i into fault_q and go to HALT.
  - Source core = lowest-index core not in fault_q.
  - error_i=1 with faulty_i zero or multi-hot: go to FAIL.
- HALT
  - halt_o is all ones.
  - When halted_i is all ones at a sampling edge: go to COPY.
  - A wait counter starts at 0 on entry. If the counter reaches HALT_TIMEOUT-1 without full acknowledge: go to FAIL.
- COPY
  - Address counter i runs 0..NUM_REG, one step per cycle.
  - While i<NUM_REG: rf_raddr_o=i.
  - While i>=1: rf_we_o=fault_q, rf_waddr_o=i-1, rf_wdata_o=rf_rdata_i.
  - State lasts NUM_REG+1 cycles, then go to PC.
- PC: pc_copy_o=1 for one cycle, then go to RESUME.
- RESUME
  - resume_o=1 for one cycle; halt_o drops to 0 in the same cycle.
  - recoveries_o increments (saturating) at the RESUME exit edge.
  - Return to IDLE.
- FAIL
  - halt_o all ones, fail_o=1; all other pulses are 0.
  - Left only by reset.
- error_i and faulty_i are ignored outside IDLE. An error still asserted on return to IDLE starts a new recovery on the next edge.
- rf_we_o is all zeros outside COPY write cycles. No bit of rf_we_o is ever set for a non-faulty core.
- Reset mid-operation: return to IDLE immediately; all outputs are 0. Partial copies are abandoned.

## Timing
- Let E0 be the edge that samples error_i=1 in IDLE. With halted_i already all ones:
  - HALT occupies cycle 1.
  - COPY occupies cycles 2..NUM_REG+2.
  - PC occupies cycle NUM_REG+3.
  - RESUME occupies cycle NUM_REG+4, i.e. cycle 36 for default parameters.
- Each cycle of halt-acknowledge delay adds exactly one cycle to the total.
- Read-to-write latency is 1 cycle. The write of address k occurs in the cycle after its read.
- busy_o is high from cycle 1 through the RESUME cycle, inclusive.

## Structure
- Shared package ft_pkg holds:
  - the state enum (IDLE, HALT, COPY, PC, RESUME, FAIL);
  - the core-index typedef;
  - the NUM_CORES constant shared with the voter.
- Sub-module copy_engine holds the address counter, read/write pipeline and done flag. It has start/done ports and is instantiated once.
- The top level holds the FSM, the timeout counter, source selection and the recovery counter.

## Test plan
- Single fault: faulty_i=3'b010, halted_i tied high, source RF[k]=k*3.
  - Core 1 receives 32 writes of addr k, data k*3.
  - rf_rsel_o=0.
  - resume_o is high in cycle 36 after E0; recoveries_o=1.
- Fault on core 0: faulty_i=3'b001. Required: rf_rsel_o=1, and only rf_we_o[0] toggles.
- Delayed acknowledge: halted_i rises 5 cycles after halt_o. Required: resume_o is high in cycle 41 and the copy data is correct.
- Timeout: halted_i[2] stuck at 0. Required: FAIL entered after 16 HALT cycles, fail_o=1, halt_o=3'b111, no rf_we_o activity.
- Multi-hot fault: faulty_i=3'b011 with error_i. Required: FAIL on the next edge and no writes.
- Mid-copy reset: rst_ni low at COPY address 10. Required: all outputs are 0 at once; after release, a new error runs a full 32-write copy.
